// File: rtl/alu_pkg.sv
// Shared opcodes, sign-select index and FSM state type for the execute-stage
// arithmetic blocks.
package alu_pkg;
    localparam logic [3:0] OP_MULT  = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam int         SIGN_BIT = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } mdState;
endpackage

// File: rtl/hilo_sign_fix.sv
// Conditional two's-complement negation of a 2*WIDTH word, either as one wide
// value (product) or as two independent WIDTH halves (operands, quotient/remainder).
module hilo_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] dataIn,
    input  logic               negWide,
    input  logic               negHi,
    input  logic               negLo,
    output logic [2*WIDTH-1:0] dataOut
);
    logic [WIDTH-1:0] hiIn;
    logic [WIDTH-1:0] loIn;
    logic [WIDTH-1:0] hiOut;
    logic [WIDTH-1:0] loOut;

    assign hiIn  = dataIn[2*WIDTH-1:WIDTH];
    assign loIn  = dataIn[WIDTH-1:0];
    assign hiOut = negHi ? (~hiIn + WIDTH'(1)) : hiIn;
    assign loOut = negLo ? (~loIn + WIDTH'(1)) : loIn;

    always_comb begin
        if (negWide) begin
            dataOut = ~dataIn + (2*WIDTH)'(1);
        end else begin
            dataOut = {hiOut, loOut};
        end
    end
endmodule

// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide engine owning HI/LO; shift-add multiply and
// restoring divide on magnitudes, sign fix-up applied before the HI/LO write.
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo writes allowed
// MUL   | one shift-add iteration per cycle
// DIV   | one restoring shift-subtract iteration per cycle
// FIX   | sign correction of the raw result, HI/LO written, done raised
module hilo_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       operation,
    input  logic [1:0]       sign,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] outHI,
    output logic [WIDTH-1:0] outLO
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    mdState             stateQ;
    mdState             stateD;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   accHi;
    logic [WIDTH-1:0]   accLo;
    logic [WIDTH-1:0]   opB;
    logic               aNeg;
    logic               bNeg;
    logic               isDivQ;
    logic [WIDTH-1:0]   hiReg;
    logic [WIDTH-1:0]   loReg;
    logic               doneQ;
    logic               dbzQ;

    logic               validOp;
    logic               accept;
    logic               isDivIn;
    logic               zeroDiv;
    logic               opSigned;
    logic               aNegIn;
    logic               bNegIn;
    logic               lastIter;
    logic               unusedSign;

    logic [2*WIDTH-1:0] fixIn;
    logic [2*WIDTH-1:0] fixOut;
    logic               fixNegWide;
    logic               fixNegHi;
    logic               fixNegLo;

    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic [WIDTH:0]     divDiff;
    logic               divFits;

    assign validOp    = (operation == OP_MULT) || (operation == OP_DIV);
    assign accept     = (stateQ == IDLE) && start && validOp;
    assign isDivIn    = (operation == OP_DIV);
    assign zeroDiv    = accept && isDivIn && (B == '0);
    assign opSigned   = sign[SIGN_BIT];
    assign unusedSign = sign[1];
    assign aNegIn     = opSigned & A[WIDTH-1];
    assign bNegIn     = opSigned & B[WIDTH-1];
    assign lastIter   = (count == CNT_W'(1));

    assign mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : '0);
    assign divShift = {accHi, accLo[WIDTH-1]};
    assign divFits  = (divShift >= {1'b0, opB});
    assign divDiff  = divShift - {1'b0, opB};

    // One sign unit: operand magnitudes while idle, result correction in FIX.
    always_comb begin
        fixIn      = {accHi, accLo};
        fixNegWide = 1'b0;
        fixNegHi   = 1'b0;
        fixNegLo   = 1'b0;
        if (stateQ == IDLE) begin
            fixIn    = {A, B};
            fixNegHi = aNegIn;
            fixNegLo = bNegIn;
        end else if (isDivQ) begin
            fixNegHi = aNeg;
            fixNegLo = aNeg ^ bNeg;
        end else begin
            fixNegWide = aNeg ^ bNeg;
        end
    end

    hilo_sign_fix #(.WIDTH(WIDTH)) u_signFix (
        .dataIn (fixIn),
        .negWide(fixNegWide),
        .negHi  (fixNegHi),
        .negLo  (fixNegLo),
        .dataOut(fixOut)
    );

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE: if (accept && !zeroDiv) stateD = isDivIn ? DIV : MUL;
            MUL,
            DIV:  if (lastIter) stateD = FIX;
            FIX:  stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            accHi  <= '0;
            accLo  <= '0;
            opB    <= '0;
            aNeg   <= 1'b0;
            bNeg   <= 1'b0;
            isDivQ <= 1'b0;
            hiReg  <= '0;
            loReg  <= '0;
            doneQ  <= 1'b0;
            dbzQ   <= 1'b0;
        end else begin
            doneQ <= 1'b0;
            case (stateQ)
                IDLE: begin
                    if (accept) begin
                        dbzQ   <= zeroDiv;
                        isDivQ <= isDivIn;
                        aNeg   <= aNegIn;
                        bNeg   <= bNegIn;
                        count  <= CNT_W'(WIDTH);
                        accHi  <= '0;
                        accLo  <= fixOut[2*WIDTH-1:WIDTH];
                        opB    <= fixOut[WIDTH-1:0];
                        if (zeroDiv) begin
                            hiReg <= A;
                            loReg <= '1;
                            doneQ <= 1'b1;
                        end
                    end else begin
                        if (hi_we) hiReg <= wdata;
                        if (lo_we) loReg <= wdata;
                    end
                end
                MUL: begin
                    accHi <= mulSum[WIDTH:1];
                    accLo <= {mulSum[0], accLo[WIDTH-1:1]};
                    count <= count - CNT_W'(1);
                end
                DIV: begin
                    accHi <= divFits ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
                    accLo <= {accLo[WIDTH-2:0], divFits};
                    count <= count - CNT_W'(1);
                end
                FIX: begin
                    hiReg <= fixOut[2*WIDTH-1:WIDTH];
                    loReg <= fixOut[WIDTH-1:0];
                    doneQ <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (stateQ != IDLE);
    assign done        = doneQ;
    assign div_by_zero = dbzQ;
    assign outHI       = hiReg;
    assign outLO       = loReg;
endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed corner cases, HI/LO write
// ports, busy-time isolation, random operations and asynchronous reset.
module tb_hilo_muldiv;
    localparam int W = 32;
    localparam logic [3:0] T_MUL = 4'b0010;
    localparam logic [3:0] T_DIV = 4'b0011;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   operation = '0;
    logic [1:0]   sign = '0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] outHI;
    logic [W-1:0] outLO;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        logic [3:0]   op;
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } vec_t;

    always #5 clk = ~clk;

    hilo_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .operation(operation), .sign(sign),
        .A(A), .B(B), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .outHI(outHI), .outLO(outLO)
    );

    // Reference: plain 64-bit arithmetic; returns {HI, LO}.
    function automatic logic [2*W-1:0] refResult(input logic isDiv, input logic sgn,
                                                 input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        if (!isDiv) begin
            p = 64'(sa * sb);
            return p;
        end
        if (b == '0) return {a, {W{1'b1}}};
        q = sa / sb;
        r = sa % sb;
        return {r[W-1:0], q[W-1:0]};
    endfunction

    // Drives one operation from the current cycle and waits for done (bounded).
    task automatic do_op(input logic [3:0] op, input logic sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, output logic [W-1:0] hi, output logic [W-1:0] lo,
                         output int lat, output int busyErr, output int earlyChg, output logic dbz);
        logic [W-1:0] h0, l0;
        h0 = outHI;
        l0 = outLO;
        busyErr = 0;
        earlyChg = 0;
        operation = op;
        sign = {1'($urandom_range(0, 1)), sgn};
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = $urandom;
        B = $urandom;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            if (busy !== 1'b1) busyErr++;
            if (outHI !== h0 || outLO !== l0) earlyChg++;
            @(posedge clk); #1;
            lat++;
        end
        if (busy !== 1'b0) busyErr++;
        hi = outHI;
        lo = outLO;
        dbz = div_by_zero;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nChecks++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            nFails++;
            $display("FAIL reset_flags: got busy/done/dbz=%b expected 000", {busy, done, div_by_zero});
        end
        nChecks++;
        if ({outHI, outLO} !== '0) begin
            nFails++;
            $display("FAIL reset_hilo: got %h_%h expected 0_0", outHI, outLO);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Consecutive entries start in the previous done cycle, so this is also back-to-back.
    task automatic test_directed();
        vec_t vecs[$];
        logic [W-1:0] hi, lo;
        int lat, bErr, eChg;
        logic dbz;
        vecs.push_back('{T_MUL, 1'b0, 32'd7,        32'd6,        32'h0,        32'd42,       1'b0});
        vecs.push_back('{T_MUL, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0});
        vecs.push_back('{T_MUL, 1'b1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0});
        vecs.push_back('{T_DIV, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
        vecs.push_back('{T_DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0});
        vecs.push_back('{T_DIV, 1'b0, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1});
        vecs.push_back('{T_MUL, 1'b0, 32'd2,        32'd3,        32'h0,        32'd6,        1'b0});
        vecs.push_back('{T_DIV, 1'b0, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0});
        vecs.push_back('{T_MUL, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1'b0});
        vecs.push_back('{T_DIV, 1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0});
        vecs.push_back('{T_DIV, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        1'b0});
        vecs.push_back('{T_DIV, 1'b1, 32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7, 32'hFFFFFFFF, 1'b1});
        vecs.push_back('{T_MUL, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'd1,        1'b0});
        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, hi, lo, lat, bErr, eChg, dbz);
            nChecks++;
            if ({hi, lo} !== {vecs[i].hi, vecs[i].lo}) begin
                nFails++;
                $display("FAIL directed[%0d]_result: got %h_%h expected %h_%h", i, hi, lo, vecs[i].hi, vecs[i].lo);
            end
            nChecks++;
            if (lat !== (vecs[i].dbz ? 1 : W + 2)) begin
                nFails++;
                $display("FAIL directed[%0d]_latency: got %0d expected %0d", i, lat, vecs[i].dbz ? 1 : W + 2);
            end
            nChecks++;
            if (dbz !== vecs[i].dbz) begin
                nFails++;
                $display("FAIL directed[%0d]_dbz: got %b expected %b", i, dbz, vecs[i].dbz);
            end
            nChecks++;
            if (bErr != 0 || eChg != 0) begin
                nFails++;
                $display("FAIL directed[%0d]_busy_hold: got busyErr=%0d earlyChange=%0d expected 0/0", i, bErr, eChg);
            end
        end
        @(posedge clk); #1;
        nChecks++;
        if (done !== 1'b0) begin
            nFails++;
            $display("FAIL done_pulse_width: got done=%b expected 0", done);
        end
    endtask

    task automatic test_mthi_mtlo();
        logic [W-1:0] hi, lo;
        int lat, bErr, eChg;
        logic dbz;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        nChecks++;
        if (outHI !== 32'hCAFE || outLO !== 32'hCAFE) begin
            nFails++;
            $display("FAIL mthi_mtlo_both: got %h_%h expected 0000cafe_0000cafe", outHI, outLO);
        end
        hi_we = 1'b1; wdata = 32'h55;
        @(posedge clk); #1;
        hi_we = 1'b0;
        nChecks++;
        if (outHI !== 32'h55 || outLO !== 32'hCAFE) begin
            nFails++;
            $display("FAIL mthi_only: got %h_%h expected 00000055_0000cafe", outHI, outLO);
        end
        // Unrecognised opcode is not an accepted start, so the write still lands.
        start = 1'b1; operation = 4'b0100; lo_we = 1'b1; wdata = 32'h77;
        @(posedge clk); #1;
        start = 1'b0; lo_we = 1'b0;
        nChecks++;
        if (busy !== 1'b0 || done !== 1'b0 || outLO !== 32'h77) begin
            nFails++;
            $display("FAIL bad_opcode: got busy=%b done=%b outLO=%h expected 0 0 00000077", busy, done, outLO);
        end
        // Accepted start has priority over mthi in the same cycle.
        start = 1'b1; operation = T_MUL; sign = 2'b00; A = 32'd2; B = 32'd3;
        hi_we = 1'b1; wdata = 32'hDEAD;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        nChecks++;
        if (busy !== 1'b1 || outHI !== 32'h55) begin
            nFails++;
            $display("FAIL start_priority: got busy=%b outHI=%h expected 1 00000055", busy, outHI);
        end
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        nChecks++;
        if (lat !== W + 2 || outHI !== 32'h0 || outLO !== 32'd6) begin
            nFails++;
            $display("FAIL priority_result: got lat=%0d %h_%h expected %0d 0_6", lat, outHI, outLO, W + 2);
        end
        do_op(T_MUL, 1'b0, 32'd1, 32'd1, hi, lo, lat, bErr, eChg, dbz);
    endtask

    task automatic test_busy_ignore();
        int lat;
        start = 1'b1; operation = T_MUL; sign = 2'b00; A = 32'd100; B = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            if (lat == 5) begin
                start = 1'b1; operation = T_DIV; A = 32'd9; B = 32'd9;
                hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234;
            end else begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        nChecks++;
        if (lat !== W + 2) begin
            nFails++;
            $display("FAIL busy_ignore_latency: got %0d expected %0d", lat, W + 2);
        end
        nChecks++;
        if (outHI !== 32'h0 || outLO !== 32'd300) begin
            nFails++;
            $display("FAIL busy_ignore_result: got %h_%h expected 0_0000012c", outHI, outLO);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] sp[5];
        logic [W-1:0] hi, lo, a, b;
        logic [2*W-1:0] exp;
        logic [3:0] op;
        logic sgn, dbz;
        int lat, bErr, eChg;
        sp = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        for (int i = 0; i < 30; i++) begin
            op  = ($urandom_range(0, 1) == 1) ? T_DIV : T_MUL;
            sgn = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 4)] : $urandom;
            b   = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(0, 31);
            exp = refResult(op == T_DIV, sgn, a, b);
            do_op(op, sgn, a, b, hi, lo, lat, bErr, eChg, dbz);
            nChecks++;
            if ({hi, lo} !== exp) begin
                nFails++;
                $display("FAIL random[%0d]_result op=%b s=%b a=%h b=%h: got %h_%h expected %h",
                         i, op, sgn, a, b, hi, lo, exp);
            end
            nChecks++;
            if (lat !== ((op == T_DIV && b == '0) ? 1 : W + 2) || bErr != 0 || eChg != 0
                || dbz !== (op == T_DIV && b == '0)) begin
                nFails++;
                $display("FAIL random[%0d]_timing: got lat=%0d busyErr=%0d earlyChange=%0d dbz=%b",
                         i, lat, bErr, eChg, dbz);
            end
        end
    endtask

    task automatic test_reset_mid();
        int doneSeen;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hABCD;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        start = 1'b1; operation = T_MUL; sign = 2'b01; A = 32'd1234; B = 32'd5678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        nChecks++;
        if ({busy, done, div_by_zero} !== 3'b000 || outHI !== '0 || outLO !== '0) begin
            nFails++;
            $display("FAIL reset_mid_op: got busy/done/dbz=%b hilo=%h_%h expected 000 0_0",
                     {busy, done, div_by_zero}, outHI, outLO);
        end
        #2;
        rst_n = 1'b1;
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) doneSeen++;
        end
        nChecks++;
        if (doneSeen != 0 || outHI !== '0 || outLO !== '0) begin
            nFails++;
            $display("FAIL reset_no_done: got activeCycles=%0d hilo=%h_%h expected 0 0_0", doneSeen, outHI, outLO);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mthi_mtlo();
        test_busy_ignore();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
